shift_sequencer: RTL and testbench



---
 rtl/shift_sequencer.sv | 112 +++++++++++
 tb/tb_shift_sequencer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
// Multi-cycle shift controller: steps a single-position shifter once per clock
// until the requested distance is covered, then presents the result with a done pulse.

module shift1 #(
  parameter int WIDTH = 16
) (
  input  logic [1:0]       ctl,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_comb begin
    q = d;
    unique case (ctl)
      2'b01:   q = {d[WIDTH-2:0], 1'b0};
      2'b10:   q = {1'b0, d[WIDTH-1:1]};
      2'b11:   q = {d[WIDTH-1], d[WIDTH-1:1]};
      default: q = d;
    endcase
  end

endmodule

// state | meaning
// IDLE  | waiting for start
// SHIFT | one single-position shift per clock, busy high
// DONE  | one-cycle done pulse, dout valid; may accept a new request
module shift_sequencer #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [CNT_W-1:0] amt,
  input  logic [WIDTH-1:0] din,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dout
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nxt;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       op_r;
  logic [1:0]       shift_ctl;
  logic             bypass;

  // The shifter only moves data while SHIFT is active; elsewhere it passes through.
  assign shift_ctl = (state == SHIFT) ? op_r : 2'b00;
  assign bypass    = (amt == '0) || (op == 2'b00);

  shift1 #(.WIDTH(WIDTH)) u_shift1 (
    .ctl (shift_ctl),
    .d   (acc),
    .q   (acc_nxt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      op_r  <= 2'b00;
      busy  <= 1'b0;
      done  <= 1'b0;
      dout  <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          busy <= 1'b0;
          state <= IDLE;
          if (start) begin
            acc  <= din;
            cnt  <= amt;
            op_r <= op;
            if (bypass) begin
              state <= DONE;
              done  <= 1'b1;
              dout  <= din;
            end else begin
              state <= SHIFT;
              busy  <= 1'b1;
            end
          end
        end
        SHIFT: begin
          acc <= acc_nxt;
          cnt <= cnt - 1'b1;
          // cnt is loaded non-zero on entry, so leaving at 1 never wraps it.
          if (cnt == CNT_W'(1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            dout  <= acc_nxt;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: expected results and done cycles are queued
// at request time and matched against each done pulse; busy is checked every cycle.

module tb_shift_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [3:0]  amt;
  logic [15:0] din;
  logic        busy;
  logic        done;
  logic [15:0] dout;

  shift_sequencer #(.WIDTH(16), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .amt   (amt),
    .din   (din),
    .busy  (busy),
    .done  (done),
    .dout  (dout)
  );

  typedef struct {
    int          sc;
    int          dc;
    logic        shifty;
    logic [15:0] val;
  } exp_t;

  exp_t q[$];
  int   cyc     = 0;
  int   free_at = 0;
  int   nvec    = 0;
  int   nerr    = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [15:0] ref_shift(input logic [15:0] d, input logic [1:0] o,
                                            input logic [3:0] n);
    logic signed [15:0] s;
    s = d;
    case (o)
      2'b01:   return d << n;
      2'b10:   return d >> n;
      2'b11:   return 16'(s >>> n);
      default: return d;
    endcase
  endfunction

  // Called right after a falling edge; start is sampled at the next rising edge.
  task automatic issue(input logic [15:0] d, input logic [1:0] o, input logic [3:0] n);
    exp_t e;
    logic byp;
    start = 1'b1;
    din   = d;
    op    = o;
    amt   = n;
    byp   = (n == 0) || (o == 2'b00);
    if (cyc >= free_at) begin
      e.sc     = cyc;
      e.dc     = cyc + (byp ? 1 : int'(n) + 1);
      e.shifty = !byp;
      e.val    = ref_shift(d, o, n);
      q.push_back(e);
      free_at  = e.dc;
    end
    @(negedge clk);
    start = 1'b0;
    din   = $urandom;
    op    = 2'($urandom);
    amt   = 4'($urandom);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      chk("timeout", q.size(), 0);
      q.delete();
    end
  endtask

  task automatic to_done();
    for (int i = 0; i < 60 && cyc < free_at; i++) @(negedge clk);
    if (cyc < free_at) chk("timeout_done", cyc, free_at);
  endtask

  always @(posedge clk) begin : monitor
    logic eb;
    #1;
    if (!reset) begin
      eb = 1'b0;
      foreach (q[i]) if (q[i].shifty && q[i].sc < cyc && cyc < q[i].dc) eb = 1'b1;
      chk("busy", busy, eb);
      if (done) begin
        if (q.size() == 0) chk("spurious_done", 1, 0);
        else begin
          chk("done_cycle", cyc, q[0].dc);
          chk("dout", dout, q[0].val);
          void'(q.pop_front());
        end
      end else if (q.size() > 0 && q[0].dc <= cyc) begin
        chk("done_missing", 0, 1);
        void'(q.pop_front());
      end
    end
  end

  initial begin
    reset = 1'b0;
    start = 1'b0;
    din   = '0;
    op    = 2'b00;
    amt   = '0;
    #2 reset = 1'b1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dout", dout, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    reset   = 1'b0;
    free_at = cyc;
    @(negedge clk);

    issue(16'h0001, 2'b01, 4'd15); wait_idle();
    issue(16'h8000, 2'b10, 4'd4);  wait_idle();
    issue(16'h8000, 2'b11, 4'd4);  wait_idle();
    issue(16'h8000, 2'b11, 4'd15); wait_idle();
    issue(16'h1234, 2'b01, 4'd0);  wait_idle();
    issue(16'hBEEF, 2'b00, 4'd7);  wait_idle();

    // start during SHIFT must be ignored
    issue(16'h00A5, 2'b01, 4'd6);
    @(negedge clk);
    issue(16'hFFFF, 2'b10, 4'd3);
    wait_idle();

    // back-to-back start in the DONE cycle
    issue(16'h0001, 2'b01, 4'd3);
    to_done();
    issue(16'h00F0, 2'b10, 4'd4);
    wait_idle();

    // consecutive zero-distance requests, then a shift right behind them
    issue(16'h1111, 2'b01, 4'd0);
    issue(16'h2222, 2'b11, 4'd0);
    issue(16'h3333, 2'b00, 4'd9);
    issue(16'hC001, 2'b11, 4'd2);
    wait_idle();

    for (int k = 0; k < 24; k++) begin
      issue(16'($urandom), 2'($urandom), 4'($urandom));
      if ($urandom_range(1) == 1) to_done();
      else wait_idle();
    end
    wait_idle();

    // reset in the middle of a shift: no done, dout cleared immediately
    issue(16'h0F0F, 2'b01, 4'd10);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_done", done, 0);
    chk("rst_mid_dout", dout, 16'h0000);
    q.delete();
    @(negedge clk);
    @(negedge clk);
    reset   = 1'b0;
    free_at = cyc;
    repeat (12) @(negedge clk);
    chk("rst_dout_hold", dout, 16'h0000);
    issue(16'h0003, 2'b01, 4'd2);
    wait_idle();
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
